chacha20_keystream_engine: RTL and testbench
============================================

// Module: chacha20_keystream_engine
// PURPOSE
//  Parametrised successor to the single-shot ChaCha20 block: a free-running keystream generator.
//  Builds the initial state from key/nonce/counter, runs ROUNDS rounds over an iterative core,
//  adds the input state, and emits 512-bit blocks on a valid/ready stream.
//  The block counter auto-increments, and the next block is computed while the current one is held.
//  Sits between key setup and the XOR datapath / LED RNG consumer.
// PARAMETERS
//  ROUNDS         20  total ChaCha rounds; legal 8, 12 or 20 (even). Other values fail elaboration.
//  UNROLL         1   double-rounds per clock; legal 1, 2 or 5; must divide ROUNDS/2.
// PORTS
//  clock          in   1    single clock; all logic on rising edge.
//  clear_n        in   1    synchronous reset, active-low.
//  load           in   1    pulse: capture key/nonce/counter_init, flush pipeline, begin streaming.
//  key            in   256  key words 0..7 = bits [32i+31:32i].
//  nonce          in   96   nonce words 0..2 = bits [32i+31:32i].
//  counter_init   in   32   first block counter.
//  block_ready    in   1    consumer accepts block_out this cycle.
//  block_valid    out  1    block_out/block_counter hold a finished keystream block.
//  block_out      out  512  keystream block; state word i at bits [32i+31:32i].
//  block_counter  out  32   counter value used for block_out.
//  busy           out  1    core is computing (state ROUND or ADD).
//  exhausted      out  1    the counter 0xFFFFFFFF block has been produced; no further blocks.
// BEHAVIOUR
//  Reset (clear_n=0, sync): state IDLE.
//   - Outputs: block_valid=0, busy=0, exhausted=0, block_out=0, block_counter=0.
//   - Captured key/nonce/counter are cleared.
//   - Reset mid-block discards all work.
//  State layout:
//   - w0..3 = 61707865, 3320646e, 79622d32, 6b206574.
//   - w4..11 = key; w12 = counter; w13..15 = nonce.
//  Core: one double-round = column QRs (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15),
//   then diagonal QRs (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14). All adds mod 2^32.
//  FSM:
//   - IDLE -> ROUND on load.
//   - ROUND: iterate; count = ROUNDS/(2*UNROLL) cycles; then -> ADD.
//   - ADD (1 cycle): result = working + initial. Then:
//       - output slot empty: write result into slot, -> NEXT;
//       - slot full: -> HOLD.
//   - HOLD: -> NEXT once the slot frees (same cycle as the handshake is allowed);
//       the held result transfers to the slot that cycle.
//   - NEXT: if the block just issued used counter 0xFFFFFFFF, set exhausted, -> IDLE;
//       else counter+=1, rebuild state, -> ROUND.
//  Latency: load at cycle 0 -> block_valid at cycle 1 + ROUNDS/(2*UNROLL) + 1.
//   - ROUNDS=20, UNROLL=1: valid in cycle 12.
//   - Steady-state: one block per ROUNDS/(2*UNROLL)+2 cycles when never stalled.
//  Handshake:
//   - Transfer when block_valid & block_ready.
//   - block_out/block_counter are stable while block_valid=1 and not accepted.
//   - block_valid falls the cycle after acceptance unless a new block loads into the slot that cycle.
//  Output slot depth is 1; the core stalls in HOLD, never drops or overwrites a block.
//  load priority:
//   - load wins over everything except reset.
//   - On load: slot invalidated (block_valid=0 next cycle, even if block_ready was high);
//     exhausted cleared; core restarts from counter_init.
//   - load in any state is legal.
//  Counter: no wrap to 0. The 0xFFFFFFFF block is emitted, then exhausted=1 until load or reset.
//   - counter_init=0xFFFFFFFF yields exactly one block.
// STRUCTURE
//  Shared package chacha20_pkg:
//   - CHACHA_CONST[4] words;
//   - state_t (16x32 array) with pack/unpack functions;
//   - quarter_round function;
//   - fsm state enum.
//  Sub-module chacha20_double_round: combinational, 512 in/512 out, 8 QRs.
//   - Instantiated UNROLL times in a chain.
//  Top holds: FSM, round counter, working/initial state regs, block counter, output slot.
// TESTING
//  RFC8439 2.3.2: key 00..1f, nonce 000000090000004a00000000, counter 1, ROUNDS=20,
//   block_ready=1 -> block_out w0=e4e7f110, w15=4e3c50a2 at cycle 12; block_counter=1.
//  Streaming: same key, 4 blocks with ready=1 -> counters 1,2,3,4.
//   - Each block matches the reference model.
//   - Valid spacing is 12 cycles.
//  Backpressure: block_ready=0 for 40 cycles.
//   - First block is held stable; busy=0 in HOLD.
//   - On release, blocks 1 and 2 are delivered back-to-back with none lost.
//  Exhaustion: counter_init=fffffffe -> two blocks (counters fffffffe, ffffffff).
//   - Then exhausted=1; no further valid for 100 cycles.
//   - load clears exhausted.
//  load mid-ROUND and coincident with a valid&ready handshake -> slot flushed.
//   - The next block carries the new counter_init.
//  clear_n=0 mid-HOLD -> next cycle block_valid=0, busy=0, exhausted=0, block_out=0.
//  Sweep ROUNDS {8,12,20} x UNROLL {1,2 where legal, 5 for ROUNDS=20}.
//   - Keystream matches the reference model; latency matches the formula.

Source files
------------

// File: rtl/chacha20_pkg.sv
// ---------------------------------------------------------------------------
// chacha20_pkg
//   Shared types and helpers for the ChaCha20 keystream engine:
//     CHACHA_CONST            - the four "expand 32-byte k" constant words
//     state_t                 - 16 x 32-bit state; word i sits at bits [32i+31:32i]
//     pack_state/unpack_state - conversions between state_t and a flat 512-bit bus
//     quarter_round           - one ChaCha QR on four selected state words
//     build_state             - initial state from key/nonce/counter
//     add_states              - word-wise mod 2^32 add (final feed-forward)
//     fsm_state_e             - engine FSM encoding
// ---------------------------------------------------------------------------
package chacha20_pkg;

    localparam logic [3:0][31:0] CHACHA_CONST = {
        32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865
    };

    typedef logic [15:0][31:0] state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROUND,
        ST_ADD,
        ST_HOLD,
        ST_NEXT
    } fsm_state_e;

    function automatic logic [511:0] pack_state(input state_t s);
        return s;
    endfunction

    function automatic state_t unpack_state(input logic [511:0] v);
        return v;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic state_t quarter_round(input state_t s,
                                             input logic [3:0] ia, input logic [3:0] ib,
                                             input logic [3:0] ic, input logic [3:0] id);
        logic [31:0] a, b, c, d;
        a = s[ia]; b = s[ib]; c = s[ic]; d = s[id];
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        s[ia] = a; s[ib] = b; s[ic] = c; s[id] = d;
        return s;
    endfunction

    function automatic state_t build_state(input logic [255:0] key,
                                           input logic [95:0]  nonce,
                                           input logic [31:0]  ctr);
        state_t s;
        s[3:0]   = CHACHA_CONST;
        s[11:4]  = key;
        s[12]    = ctr;
        s[15:13] = nonce;
        return s;
    endfunction

    function automatic state_t add_states(input state_t x, input state_t y);
        state_t r;
        for (int i = 0; i < 16; i++) begin
            r[i] = x[i] + y[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/chacha20_keystream_engine_if.sv
// ---------------------------------------------------------------------------
// chacha20_keystream_engine_if
//   Keystream block stream (valid/ready).
//     block_valid   - slot holds a finished keystream block
//     block_ready   - consumer accepts the block this cycle
//     block_out     - 512-bit keystream block, state word i at [32i+31:32i]
//     block_counter - block counter used to generate block_out
//   master: the engine (producer); slave: the consumer.
// ---------------------------------------------------------------------------
interface chacha20_keystream_engine_if;

    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_out;
    logic [31:0]  block_counter;

    modport master (
        output block_valid,
        output block_out,
        output block_counter,
        input  block_ready
    );

    modport slave (
        input  block_valid,
        input  block_out,
        input  block_counter,
        output block_ready
    );

endinterface

// File: rtl/chacha20_double_round.sv
// ---------------------------------------------------------------------------
// chacha20_double_round
//   Purely combinational ChaCha double round: four column QRs followed by
//   four diagonal QRs.
//     state_in  - 512-bit working state
//     state_out - state after one double round
// ---------------------------------------------------------------------------
module chacha20_double_round
    import chacha20_pkg::*;
(
    input  logic [511:0] state_in,
    output logic [511:0] state_out
);

    state_t s;

    always_comb begin
        s = unpack_state(state_in);
        // columns
        s = quarter_round(s, 4'd0, 4'd4, 4'd8,  4'd12);
        s = quarter_round(s, 4'd1, 4'd5, 4'd9,  4'd13);
        s = quarter_round(s, 4'd2, 4'd6, 4'd10, 4'd14);
        s = quarter_round(s, 4'd3, 4'd7, 4'd11, 4'd15);
        // diagonals
        s = quarter_round(s, 4'd0, 4'd5, 4'd10, 4'd15);
        s = quarter_round(s, 4'd1, 4'd6, 4'd11, 4'd12);
        s = quarter_round(s, 4'd2, 4'd7, 4'd8,  4'd13);
        s = quarter_round(s, 4'd3, 4'd4, 4'd9,  4'd14);
        state_out = pack_state(s);
    end

endmodule

// File: rtl/chacha20_keystream_engine.sv
// ---------------------------------------------------------------------------
// chacha20_keystream_engine
//   Free-running ChaCha20 keystream generator. A load pulse captures
//   key/nonce/counter_init and starts streaming; each block runs ROUNDS
//   rounds (UNROLL double rounds per clock), adds the initial state and is
//   handed to a one-deep output slot. The counter auto-increments and the next
//   block computes while the current one waits in the slot.
//   Ports:
//     clock, clear_n      - clock, synchronous active-low reset
//     load                - capture inputs, flush, restart streaming
//     key/nonce/counter_init - block inputs
//     blk (master)        - block_valid/ready/out/counter stream
//     busy                - core in ROUND or ADD
//     exhausted           - counter 0xFFFFFFFF block produced; stream stopped
// ---------------------------------------------------------------------------
module chacha20_keystream_engine
    import chacha20_pkg::*;
#(
    parameter int ROUNDS = 20,
    parameter int UNROLL = 1
) (
    input  logic                                clock,
    input  logic                                clear_n,
    input  logic                                load,
    input  logic [255:0]                        key,
    input  logic [95:0]                         nonce,
    input  logic [31:0]                         counter_init,
    chacha20_keystream_engine_if.master         blk,
    output logic                                busy,
    output logic                                exhausted
);

    localparam int ITERS = ROUNDS / (2 * UNROLL);
    localparam int CW    = $clog2(ITERS) + 1;

    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
        $error("ROUNDS must be 8, 12 or 20");
    end
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5) || ((ROUNDS / 2) % UNROLL) != 0) begin : g_bad_unroll
        $error("UNROLL must be 1, 2 or 5 and divide ROUNDS/2");
    end

    fsm_state_e    state_q, state_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [255:0]  key_q, key_d;
    logic [95:0]   nonce_q, nonce_d;
    logic [31:0]   ctr_q, ctr_d;
    logic [511:0]  work_q, work_d;
    logic          slot_vld_q, slot_vld_d;
    logic [511:0]  slot_data_q, slot_data_d;
    logic [31:0]   slot_ctr_q, slot_ctr_d;
    logic          busy_q, busy_d;
    logic          exh_q, exh_d;

    // The initial state is rebuilt from the captured inputs rather than
    // stored; ctr_q is constant across ROUND/ADD so it matches the block.
    state_t init_s, sum_s;
    assign init_s = build_state(key_q, nonce_q, ctr_q);
    assign sum_s  = add_states(unpack_state(work_q), init_s);

    logic [UNROLL:0][511:0] chain;
    assign chain[0] = work_q;
    for (genvar g = 0; g < UNROLL; g++) begin : g_dr
        chacha20_double_round u_dr (
            .state_in  (chain[g]),
            .state_out (chain[g+1])
        );
    end

    // Slot can take a new block when empty or being drained this cycle.
    logic handshake, slot_free;
    assign handshake = slot_vld_q & blk.block_ready;
    assign slot_free = ~slot_vld_q | blk.block_ready;

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        key_d       = key_q;
        nonce_d     = nonce_q;
        ctr_d       = ctr_q;
        work_d      = work_q;
        slot_vld_d  = slot_vld_q & ~handshake;
        slot_data_d = slot_data_q;
        slot_ctr_d  = slot_ctr_q;
        exh_d       = exh_q;

        case (state_q)
            ST_ROUND: begin
                work_d = chain[UNROLL];
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == CW'(ITERS - 1)) state_d = ST_ADD;
            end
            ST_ADD: begin
                if (slot_free) begin
                    slot_vld_d  = 1'b1;
                    slot_data_d = pack_state(sum_s);
                    slot_ctr_d  = ctr_q;
                    state_d     = ST_NEXT;
                end else begin
                    // park the finished block in the working register
                    work_d  = pack_state(sum_s);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (slot_free) begin
                    slot_vld_d  = 1'b1;
                    slot_data_d = work_q;
                    slot_ctr_d  = ctr_q;
                    state_d     = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (ctr_q == 32'hffff_ffff) begin
                    exh_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ctr_d   = ctr_q + 32'd1;
                    work_d  = pack_state(build_state(key_q, nonce_q, ctr_q + 32'd1));
                    rcnt_d  = '0;
                    state_d = ST_ROUND;
                end
            end
            default: ;
        endcase

        if (load) begin
            key_d      = key;
            nonce_d    = nonce;
            ctr_d      = counter_init;
            work_d     = pack_state(build_state(key, nonce, counter_init));
            rcnt_d     = '0;
            slot_vld_d = 1'b0;
            exh_d      = 1'b0;
            state_d    = ST_ROUND;
        end

        busy_d = (state_d == ST_ROUND) || (state_d == ST_ADD);
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q     <= ST_IDLE;
            rcnt_q      <= '0;
            key_q       <= '0;
            nonce_q     <= '0;
            ctr_q       <= '0;
            work_q      <= '0;
            slot_vld_q  <= 1'b0;
            slot_data_q <= '0;
            slot_ctr_q  <= '0;
            busy_q      <= 1'b0;
            exh_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            key_q       <= key_d;
            nonce_q     <= nonce_d;
            ctr_q       <= ctr_d;
            work_q      <= work_d;
            slot_vld_q  <= slot_vld_d;
            slot_data_q <= slot_data_d;
            slot_ctr_q  <= slot_ctr_d;
            busy_q      <= busy_d;
            exh_q       <= exh_d;
        end
    end

    assign blk.block_valid   = slot_vld_q;
    assign blk.block_out     = slot_data_q;
    assign blk.block_counter = slot_ctr_q;
    assign busy              = busy_q;
    assign exhausted         = exh_q;

endmodule

// File: tb/tb_chacha20_keystream_engine.sv
// ---------------------------------------------------------------------------
// tb_chacha20_keystream_engine
//   Scoreboard bench: expected blocks are queued from a reference model when
//   a load is driven and compared as the DUT hands blocks out. A set of extra
//   instances covers the ROUNDS/UNROLL combinations.
// ---------------------------------------------------------------------------
module tb_chacha20_keystream_engine;

    localparam int NSW = 6;
    localparam int SW_R [NSW] = '{8, 8, 12, 12, 20, 20};
    localparam int SW_U [NSW] = '{1, 2, 1, 2, 2, 5};
    localparam int QI [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                                 '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};

    logic         clock = 1'b0;
    logic         clear_n = 1'b0;
    logic         load = 1'b0;
    logic         sw_load = 1'b0;
    logic [255:0] key = '0;
    logic [95:0]  nonce = '0;
    logic [31:0]  counter_init = '0;
    logic         busy, exhausted;

    chacha20_keystream_engine_if blk();

    chacha20_keystream_engine #(.ROUNDS(20), .UNROLL(1)) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .load         (load),
        .key          (key),
        .nonce        (nonce),
        .counter_init (counter_init),
        .blk          (blk),
        .busy         (busy),
        .exhausted    (exhausted)
    );

    logic [NSW-1:0]        sw_valid, sw_busy, sw_exh;
    logic [NSW-1:0][511:0] sw_out;
    logic [NSW-1:0][31:0]  sw_ctr;

    for (genvar gi = 0; gi < NSW; gi++) begin : g_sw
        chacha20_keystream_engine_if sif();
        assign sif.block_ready = 1'b1;
        assign sw_valid[gi]    = sif.block_valid;
        assign sw_out[gi]      = sif.block_out;
        assign sw_ctr[gi]      = sif.block_counter;
        chacha20_keystream_engine #(.ROUNDS(SW_R[gi]), .UNROLL(SW_U[gi])) u_sw (
            .clock        (clock),
            .clear_n      (clear_n),
            .load         (sw_load),
            .key          (key),
            .nonce        (nonce),
            .counter_init (counter_init),
            .blk          (sif),
            .busy         (sw_busy[gi]),
            .exhausted    (sw_exh[gi])
        );
    end

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]  ctr;
        logic [511:0] data;
    } exp_t;
    exp_t sbq[$];

    int vec_cnt = 0;
    int err_cnt = 0;
    int c0 = 0;

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] bc, input int rounds);
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [511:0] r;
        int a, b, c, d;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = bc;
        for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
        x = s;
        for (int rr = 0; rr < rounds / 2; rr++) begin
            for (int q = 0; q < 8; q++) begin
                a = QI[q][0]; b = QI[q][1]; c = QI[q][2]; d = QI[q][3];
                x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 7);
            end
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge: drive load for one cycle, queue expectations.
    task automatic do_load(input logic [31:0] ci, input logic rdy, input int nexp);
        exp_t e;
        counter_init      = ci;
        load              = 1'b1;
        blk.block_ready   = rdy;
        sbq.delete();
        for (int j = 0; j < nexp; j++) begin
            e.ctr  = ci + 32'(j);
            e.data = ref_block(key, nonce, e.ctr, 20);
            sbq.push_back(e);
            if (e.ctr == 32'hffff_ffff) break;
        end
        c0 = cyc;
        @(negedge clock);
        load = 1'b0;
    endtask

    // Wait (bounded) for a handshake and compare against the scoreboard head.
    task automatic take(input string tag, output int at, output logic [511:0] dat);
        exp_t e;
        bit   got;
        got = 1'b0;
        at  = -1;
        dat = '0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (blk.block_valid && blk.block_ready) begin
                got = 1'b1;
                at  = cyc;
                dat = blk.block_out;
                if (sbq.size() == 0) begin
                    chk({tag, "_unexpected"}, 512'd1, 512'd0);
                end else begin
                    e = sbq.pop_front();
                    chk({tag, "_data"}, blk.block_out, e.data);
                    chk({tag, "_ctr"}, 512'(blk.block_counter), 512'(e.ctr));
                end
            end
            @(negedge clock);
        end
        if (!got) chk({tag, "_timeout"}, 512'd0, 512'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, cnt, changes;
        logic [511:0] d, prev;
        bit seen;
        logic [NSW-1:0] sw_seen;

        for (int i = 0; i < 32; i++) key[8*i +: 8] = 8'(i);
        nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
        blk.block_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_valid", 512'(blk.block_valid), 512'd0);
        chk("rst_busy", 512'(busy), 512'd0);
        chk("rst_exh", 512'(exhausted), 512'd0);
        chk("rst_out", blk.block_out, 512'd0);
        chk("rst_ctr", 512'(blk.block_counter), 512'd0);
        chk("rst_sw_busy", 512'(sw_busy), 512'd0);
        clear_n = 1'b1;
        @(negedge clock);

        // RFC 8439 2.3.2 vector, then streaming counters 2..4
        do_load(32'd1, 1'b1, 4);
        take("rfc", t0, d);
        chk("rfc_lat", 512'(t0 - c0), 512'd12);
        chk("rfc_w0", 512'(d[31:0]), 512'(32'he4e7f110));
        chk("rfc_w15", 512'(d[511:480]), 512'(32'h4e3c50a2));
        for (int b = 1; b < 4; b++) begin
            take("strm", t1, d);
            chk("strm_gap", 512'(t1 - t0), 512'd12);
            t0 = t1;
        end

        // backpressure: hold 40 cycles, then drain
        do_load(32'd10, 1'b0, 3);
        changes = 0;
        seen = 1'b0;
        prev = '0;
        repeat (40) begin
            if (blk.block_valid) begin
                if (seen && blk.block_out !== prev) changes++;
                seen = 1'b1;
                prev = blk.block_out;
            end
            @(negedge clock);
        end
        chk("bp_valid", 512'(blk.block_valid), 512'd1);
        chk("bp_busy", 512'(busy), 512'd0);
        chk("bp_ctr", 512'(blk.block_counter), 512'd10);
        chk("bp_data", blk.block_out, sbq[0].data);
        chk("bp_stable", 512'(changes), 512'd0);
        blk.block_ready = 1'b1;
        take("bp0", t0, d);
        take("bp1", t1, d);
        take("bp2", t2, d);
        chk("bp_b2b", 512'(t1 - t0), 512'd1);
        chk("bp_gap", 512'(t2 - t1), 512'd12);

        // exhaustion
        do_load(32'hffff_fffe, 1'b1, 4);
        take("exh0", t0, d);
        take("exh1", t1, d);
        cnt = 0;
        repeat (100) begin
            if (blk.block_valid) cnt++;
            @(negedge clock);
        end
        chk("exh_no_valid", 512'(cnt), 512'd0);
        chk("exh_flag", 512'(exhausted), 512'd1);

        // load clears exhausted; then load mid-ROUND with a handshake pending
        do_load(32'd100, 1'b0, 1);
        chk("exh_clr", 512'(exhausted), 512'd0);
        for (int k = 0; k < 40 && !blk.block_valid; k++) @(negedge clock);
        repeat (3) @(negedge clock);
        chk("mid_valid", 512'(blk.block_valid), 512'd1);
        chk("mid_ctr", 512'(blk.block_counter), 512'd100);
        chk("mid_busy", 512'(busy), 512'd1);
        do_load(32'd200, 1'b1, 2);
        chk("mid_flush", 512'(blk.block_valid), 512'd0);
        take("mid", t0, d);
        chk("mid_lat", 512'(t0 - c0), 512'd12);

        // reset while holding a block
        do_load(32'd7, 1'b0, 1);
        repeat (30) @(negedge clock);
        chk("hold_valid", 512'(blk.block_valid), 512'd1);
        chk("hold_busy", 512'(busy), 512'd0);
        clear_n = 1'b0;
        @(negedge clock);
        chk("clr_valid", 512'(blk.block_valid), 512'd0);
        chk("clr_busy", 512'(busy), 512'd0);
        chk("clr_exh", 512'(exhausted), 512'd0);
        chk("clr_out", blk.block_out, 512'd0);
        clear_n = 1'b1;
        @(negedge clock);

        // ROUNDS x UNROLL sweep
        counter_init = 32'd3;
        sw_load = 1'b1;
        c0 = cyc;
        @(negedge clock);
        sw_load = 1'b0;
        sw_seen = '0;
        repeat (40) begin
            for (int i = 0; i < NSW; i++) begin
                if (!sw_seen[i] && sw_valid[i]) begin
                    sw_seen[i] = 1'b1;
                    chk($sformatf("sw%0d_lat", i), 512'(cyc - c0),
                        512'(2 + SW_R[i] / (2 * SW_U[i])));
                    chk($sformatf("sw%0d_data", i), sw_out[i],
                        ref_block(key, nonce, 32'd3, SW_R[i]));
                    chk($sformatf("sw%0d_ctr", i), 512'(sw_ctr[i]), 512'd3);
                end
            end
            @(negedge clock);
        end
        chk("sw_all_seen", 512'(sw_seen), 512'({NSW{1'b1}}));
        chk("sw_exh", 512'(sw_exh), 512'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
